pipe_regs: RTL and testbench

PIPE_REGS -- requirements
Module: pipe_regs

---
 rtl/pipe_regs.sv | 93 +++++++++
 tb/tb_pipe_regs.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_regs.sv
// pipe_regs: DEPTH-stage valid/ready register pipeline with bubble collapse.
// Each stage holds a valid bit and a data word. The ready chain runs
// combinationally from the output back to the input, so an empty stage always
// loads and a stalled output never blocks upstream stages that have empty slots.
// Invalid stages always hold RESET_VAL.
module pipe_regs #(
  parameter int unsigned      WIDTH     = 32,
  parameter int unsigned      DEPTH     = 3,
  parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(32'h0000_0013)
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] v_q, v_d;
  logic [WIDTH-1:0] d_q [DEPTH];
  logic [WIDTH-1:0] d_d [DEPTH];
  logic [OCC_W-1:0] occupancy_q, occupancy_d;
  logic [DEPTH:0]   rdy;

  // Ready chain: a stage can accept when it is empty or its successor accepts.
  always_comb begin
    rdy        = '0;
    rdy[DEPTH] = out_ready;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      rdy[DEPTH-1-k] = ~v_q[DEPTH-1-k] | rdy[DEPTH-k];
    end
  end

  assign in_ready = rdy[0] & ~flush;

  // Next-state for every stage, with flush overriding all loads; the registered
  // occupancy is counted from the next valid vector so it tracks v in the same edge.
  always_comb begin
    v_d         = v_q;
    d_d         = d_q;
    occupancy_d = '0;
    if (flush) begin
      v_d = '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
        d_d[k] = RESET_VAL;
      end
    end else begin
      if (rdy[0]) begin
        v_d[0] = in_valid;
        d_d[0] = in_valid ? in_data : RESET_VAL;
      end
      // Upstream invalid stages already hold RESET_VAL, so a plain copy keeps
      // the invariant without a second mux per stage.
      for (int unsigned k = 1; k < DEPTH; k++) begin
        if (rdy[k]) begin
          v_d[k] = v_q[k-1];
          d_d[k] = d_q[k-1];
        end
      end
    end
    for (int unsigned k = 0; k < DEPTH; k++) begin
      occupancy_d = occupancy_d + OCC_W'(v_d[k]);
    end
  end

  // Stage registers and occupancy counter with asynchronous active-low reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      v_q         <= '0;
      occupancy_q <= '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
        d_q[k] <= RESET_VAL;
      end
    end else begin
      v_q         <= v_d;
      occupancy_q <= occupancy_d;
      for (int unsigned k = 0; k < DEPTH; k++) begin
        d_q[k] <= d_d[k];
      end
    end
  end

  assign out_valid = v_q[DEPTH-1];
  assign out_data  = d_q[DEPTH-1];
  assign occupancy = occupancy_q;

endmodule

// File: tb/tb_pipe_regs.sv
// tb_pipe_regs: directed and randomized checks of pipe_regs (WIDTH=32, DEPTH=3).
// The reference model keeps stored words in an ordered queue, each tagged with
// its stage position; every edge each word advances one position unless blocked
// by the word ahead of it, and the oldest word leaves from the last position.
module tb_pipe_regs;

  localparam int          WIDTH = 32;
  localparam int          DEPTH = 3;
  localparam logic [31:0] RV    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        out_ready = 1'b0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic [1:0]  occupancy;

  int n_cmp = 0;
  int n_bad = 0;

  pipe_regs #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .RESET_VAL(RV)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .flush(flush),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_ready(out_ready),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: oldest word at the front, positions 0..DEPTH-1.
  logic [31:0] mq_d[$];
  int          mq_p[$];
  int          np_q[$];
  bit          pop_b;

  // Plan the positions after the next edge given out_ready (no flush).
  function automatic void m_plan(input bit ordy);
    int bound;
    int n;
    np_q.delete();
    pop_b = (mq_p.size() > 0) && (mq_p[0] == DEPTH - 1) && ordy;
    bound = DEPTH;
    foreach (mq_p[k]) begin
      if (k == 0 && pop_b) begin
        np_q.push_back(DEPTH);
      end else begin
        n = mq_p[k] + 1;
        if (n > bound - 1) n = bound - 1;
        np_q.push_back(n);
        bound = n;
      end
    end
  endfunction

  function automatic bit m_in_ready(input bit fl);
    return !fl && (np_q.size() == 0 || np_q[np_q.size()-1] > 0);
  endfunction

  // Compare DUT against the model on every falling edge.
  always @(negedge clk) begin : cmp
    bit          exp_v;
    logic [31:0] exp_d;
    m_plan(out_ready);
    exp_v = (mq_p.size() > 0) && (mq_p[0] == DEPTH - 1);
    exp_d = exp_v ? mq_d[0] : RV;
    chk("in_ready", 32'(in_ready), 32'(m_in_ready(flush)));
    chk("out_valid", 32'(out_valid), 32'(exp_v));
    chk("out_data", out_data, exp_d);
    chk("occupancy", 32'(occupancy), 32'(mq_d.size()));
  end

  // Advance the model on each rising edge.
  always @(posedge clk) begin : mdl
    bit acc;
    if (resetn) begin
      if (flush) begin
        mq_d.delete();
        mq_p.delete();
      end else begin
        m_plan(out_ready);
        acc = in_valid && m_in_ready(1'b0);
        if (pop_b) begin
          void'(mq_d.pop_front());
          void'(mq_p.pop_front());
          void'(np_q.pop_front());
        end
        foreach (mq_p[k]) mq_p[k] = np_q[k];
        if (acc) begin
          mq_d.push_back(in_data);
          mq_p.push_back(0);
        end
      end
    end
  end

  always @(negedge resetn) begin
    mq_d.delete();
    mq_p.delete();
  end

  task automatic drive(input bit iv, input logic [31:0] id, input bit ordy, input bit fl);
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    flush     = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input bit iv, input logic [31:0] id, input bit ordy, input bit fl);
    drive(iv, id, ordy, fl);
    tick();
  endtask

  initial begin
    // Reset held: outputs cleared, in_ready follows the empty ready chain.
    tick();
    tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'h13);
    chk("rst_occupancy", 32'(occupancy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    resetn = 1'b1;
    step(1'b0, '0, 1'b1, 1'b0);
    chk("idle_out_valid", 32'(out_valid), 32'd0);
    chk("idle_out_data", out_data, 32'h13);
    chk("idle_occupancy", 32'(occupancy), 32'd0);
    chk("idle_in_ready", 32'(in_ready), 32'd1);

    // Back-to-back stream: 3-cycle latency then one word per cycle.
    step(1'b1, 32'h1, 1'b1, 1'b0);
    step(1'b1, 32'h2, 1'b1, 1'b0);
    chk("lat_early_valid", 32'(out_valid), 32'd0);
    step(1'b1, 32'h3, 1'b1, 1'b0);
    chk("stream_w1", out_data, 32'h1);
    step(1'b1, 32'h4, 1'b1, 1'b0);
    chk("stream_w2", out_data, 32'h2);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("stream_w3", out_data, 32'h3);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("stream_w4", out_data, 32'h4);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("stream_drained", 32'(out_valid), 32'd0);

    // Fill with output stalled, then drain with simultaneous in/out.
    step(1'b1, 32'hA, 1'b0, 1'b0);
    step(1'b1, 32'hB, 1'b0, 1'b0);
    step(1'b1, 32'hC, 1'b0, 1'b0);
    chk("full_occupancy", 32'(occupancy), 32'd3);
    drive(1'b1, 32'hD, 1'b0, 1'b0);
    #1;
    chk("full_stall_in_ready", 32'(in_ready), 32'd0);
    tick();
    chk("full_hold_occ", 32'(occupancy), 32'd3);
    chk("full_hold_data", out_data, 32'hA);
    drive(1'b1, 32'hD, 1'b1, 1'b0);
    #1;
    chk("full_flow_in_ready", 32'(in_ready), 32'd1);
    tick();
    chk("drain_b", out_data, 32'hB);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("drain_c", out_data, 32'hC);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("drain_d", out_data, 32'hD);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("drain_empty", 32'(out_valid), 32'd0);

    // Bubble collapse behind a stalled output.
    step(1'b1, 32'hA, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b1, 32'hB, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("bubble_occ", 32'(occupancy), 32'd2);
    chk("bubble_out", out_data, 32'hA);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("bubble_next", out_data, 32'hB);
    step(1'b0, '0, 1'b1, 1'b0);

    // Flush a full pipe with a word offered at the same edge.
    step(1'b1, 32'h5, 1'b0, 1'b0);
    step(1'b1, 32'h6, 1'b0, 1'b0);
    step(1'b1, 32'h7, 1'b0, 1'b0);
    drive(1'b1, 32'h8, 1'b0, 1'b1);
    #1;
    chk("flush_in_ready", 32'(in_ready), 32'd0);
    tick();
    chk("flush_occ", 32'(occupancy), 32'd0);
    chk("flush_valid", 32'(out_valid), 32'd0);
    chk("flush_data", out_data, 32'h13);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, '0, 1'b1, 1'b0);
      chk("flush_no_emit", 32'(out_valid), 32'd0);
    end

    // Asynchronous reset mid-stream, then latency after release.
    step(1'b1, 32'h21, 1'b1, 1'b0);
    step(1'b1, 32'h22, 1'b1, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0);
    #2 resetn = 1'b0;
    #1;
    chk("async_valid", 32'(out_valid), 32'd0);
    chk("async_occ", 32'(occupancy), 32'd0);
    chk("async_data", out_data, 32'h13);
    tick();
    resetn = 1'b1;
    step(1'b1, 32'h9, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("post_rst_early", 32'(out_valid), 32'd0);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("post_rst_word", out_data, 32'h9);
    chk("post_rst_valid", 32'(out_valid), 32'd1);

    // Randomized traffic with occasional flush and asynchronous reset pulses.
    for (int c = 0; c < 3000; c++) begin
      drive($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 9) < 6,
            $urandom_range(0, 49) == 0);
      if ($urandom_range(0, 199) == 0) begin
        #2 resetn = 1'b0;
        #1;
        chk("rand_async_valid", 32'(out_valid), 32'd0);
        tick();
        resetn = 1'b1;
      end else begin
        tick();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
